// File: rtl/width_n_to_wide.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_W bits into one word, with valid/ready on both sides.
// Optional emitted-word counter enabled by defining WIDTH_N_TO_WIDE_CNT_EN.
module width_n_to_wide #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  last_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      keep_out,
    output logic                  last_out,
    output logic [15:0]           word_cnt
);

    localparam int CW = $clog2(RATIO);
    localparam int WW = IN_W * RATIO;

    logic [CW-1:0]    cnt;
    logic [WW-1:0]    asm_data;
    logic [RATIO-1:0] asm_keep;

    logic             accept;
    logic             emit;
    logic             final_beat;
    logic [CW-1:0]    lane;
    logic [WW-1:0]    merged_data;
    logic [RATIO-1:0] merged_keep;

    assign ready_in   = !valid_out || ready_out;
    assign accept     = valid_in && ready_in;
    assign emit       = valid_out && ready_out;
    assign final_beat = accept && ((cnt == CW'(RATIO - 1)) || last_in);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        lane        = (MSB_FIRST != 0) ? (CW'(RATIO - 1) - cnt) : cnt;
        merged_data = asm_data;
        merged_keep = asm_keep;
        merged_data[lane*IN_W +: IN_W] = data_in;
        merged_keep[lane]              = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    // The assembly buffer is cleared on close, which leaves unfilled lanes of the next word at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (final_beat) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (accept) begin
            cnt      <= cnt + CW'(1);
            asm_data <= merged_data;
            asm_keep <= merged_keep;
        end
    end

    // A closing beat overrides a simultaneous emission so back-to-back words leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (final_beat) begin
            valid_out <= 1'b1;
            data_out  <= merged_data;
            keep_out  <= merged_keep;
            last_out  <= last_in;
        end else if (emit) begin
            valid_out <= 1'b0;
        end
    end

`ifdef WIDTH_N_TO_WIDE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (emit && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule

// File: doc/width_n_to_wide.md
# width_n_to_wide

Parametrised narrow-to-wide stream packer: accumulates RATIO consecutive IN_W-bit input beats into one IN_W*RATIO-bit output word. It generalises the fixed 8-to-16 stitcher with valid/ready backpressure on both sides, early word close on `last_in` with lane-enable reporting, and selectable lane order. It sits between a narrow producer (byte-serial receiver, DMA read port) and a wide datapath consumer.

## Interface
- `IN_W`, 8, input beat width in bits (≥1)
- `RATIO`, 2, beats per output word (2..16)
- `MSB_FIRST`, 1, 1: first beat lands in the most significant lane; 0: least significant lane
- `clk` input 1 — single clock, all logic on rising edge
- `rst` input 1 — reset, synchronous, active-high
- `valid_in` input 1 — input beat valid
- `ready_in` output 1 — block accepts a beat this cycle
- `data_in` input IN_W — input beat
- `last_in` input 1 — beat closes the current word early (qualified by valid_in)
- `valid_out` output 1 — output word valid
- `ready_out` input 1 — consumer accepts output word
- `data_out` output IN_W*RATIO — packed word
- `keep_out` output RATIO — per-lane filled flag, bit i ↔ lane i (lane 0 = bits IN_W-1:0)
- `last_out` output 1 — word was closed by `last_in`
- `word_cnt` output 16 — emitted-word counter (only with WIDTH_N_TO_WIDE_CNT_EN)

## Operation
- Beat accepted ⇔ `valid_in && ready_in`; word emitted ⇔ `valid_out && ready_out`.
- `ready_in = !valid_out || ready_out` (combinational from ready_out and state only; never depends on valid_in).
- Lane counter `cnt` 0..RATIO-1; beat k of a word goes to lane RATIO-1-k (MSB_FIRST=1) or lane k (MSB_FIRST=0).
- Non-final accepted beat: written to assembly buffer lane, its keep bit set, `cnt` increments.
- Final beat = accepted beat with `cnt==RATIO-1` or `last_in=1`: buffer contents plus this beat loaded into output register; `keep_out` = filled lanes; unfilled lanes of `data_out` = 0; `last_out = last_in`; buffer keep bits and `cnt` cleared same edge.
- `last_in` on beat RATIO-1 gives full word with `last_out=1`, `keep_out` all ones.
- Output register holds data/keep/last stable while `valid_out && !ready_out`; after emission with no new word, `valid_out` drops, data_out/keep_out/last_out hold last values.
- Emission and new final beat in same cycle: new word replaces old, `valid_out` stays 1 (no bubble).
- `valid_in` with `ready_in=0`: beat ignored, state unchanged.

## Timing
- Reset (synchronous, rst=1 at edge): `valid_out=0`, `data_out=0`, `keep_out=0`, `last_out=0`, `word_cnt=0`, `cnt=0`, buffer cleared; `ready_in=1` the cycle after.
- Reset mid-word or with word pending: partial and pending data discarded, no emission.
- Latency: `valid_out` rises on the edge that accepts the final beat (1 cycle after final beat presented).
- Sustained throughput: one beat per cycle, one word per RATIO cycles with `ready_out` held high.
- Stall: with `valid_out=1, ready_out=0`, `ready_in=0`; no beats accepted, including non-final ones.

## Configuration
- `WIDTH_N_TO_WIDE_CNT_EN` defined: `word_cnt` increments by 1 on each emission, saturates at 16'hFFFF, cleared by reset.
- Not defined: `word_cnt` port present, tied to 0; no counter logic.

## Test plan
- IN_W=8, RATIO=2, MSB_FIRST=1, ready_out=1: beats 8'hA5, 8'h3C back-to-back → one cycle after second beat `data_out=16'hA53C`, `keep_out=2'b11`, `last_out=0`, `valid_out` high 1 cycle.
- RATIO=4, MSB_FIRST=0: beats 11,22,33(last_in=1) → `data_out=32'h00332211`, `keep_out=4'b0111`, `last_out=1`; next beats start at lane 0.
- RATIO=4, 8 continuous beats 01..08, ready_out=1 → words 32'h01020304, 32'h05060708 at cycles 4 and 8, `ready_in` never low.
- Word pending, ready_out=0 for 5 cycles while valid_in=1 → `ready_in=0`, data_out stable, no beats lost; ready_out=1 → emission, accepting resumes same cycle.
- Two beats into RATIO=4 word then rst=1 one cycle → all outputs 0; next 4 beats form a complete fresh word with no stale lanes.
- CNT_EN defined, 3 words emitted → `word_cnt=3`; undefined → `word_cnt=0`.
